// File: rtl/vga_timing_pattern.sv
// Programmable VGA timing generator with four selectable test patterns.
// A pixel-rate strobe advances (h, v) counters; every output is registered
// from the decode of the new position on the strobe, so all outputs are
// mutually aligned and hold between strobes. The pattern select is latched
// on the pixel (0,0) strobe and governs the whole frame.
module vga_timing_pattern #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int PXL_DIV  = 2,
    parameter int COLOR_W  = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               pxlen,
    output logic               active,
    output logic [11:0]        hcount,
    output logic [11:0]        vcount,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PXL_DIV > 1) ? $clog2(PXL_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PXL_DIV - 1);
    localparam logic [11:0]      H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]      V_LAST   = 12'(V_TOTAL - 1);
    // 13-bit bounds so a sync end equal to 4096 is still representable
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [COLOR_W-1:0] FULL = '1;

    logic [DIV_W-1:0]   div_reg;
    logic [11:0]        h_reg, v_reg;
    logic [1:0]         mode_reg;
    logic               tick;
    logic [11:0]        h_next, v_next;
    logic [12:0]        h_wide, v_wide;
    logic               frame_next, act_next, hs_next, vs_next;
    logic [1:0]         mode_eff;
    logic [6:0]         bar_ge;
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] grad, r_next, g_next, b_next;

    assign tick       = (div_reg == DIV_LAST);
    assign h_wide     = {1'b0, h_next};
    assign v_wide     = {1'b0, v_next};
    assign frame_next = (h_next == 12'd0) && (v_next == 12'd0);
    assign act_next   = (h_wide < H_ACT) && (v_wide < V_ACT);
    assign hs_next    = ((h_wide >= HS_START) && (h_wide < HS_END)) ? SYNC_POL : !SYNC_POL;
    assign vs_next    = ((v_wide >= VS_START) && (v_wide < VS_END)) ? SYNC_POL : !SYNC_POL;
    // The frame's first pixel already shows the newly sampled mode
    assign mode_eff   = frame_next ? mode : mode_reg;

    // Colour-bar edges: bar_ge[gi] set when h is at or beyond edge gi+1
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar
        localparam logic [12:0] EDGE = 13'((gi + 1) * H_ACTIVE / 8);
        assign bar_ge[gi] = (h_wide >= EDGE);
    end

    // Gradient: column zero-extended or truncated to the channel width
    if (COLOR_W <= 12) begin : g_grad_trunc
        assign grad = h_next[COLOR_W-1:0];
    end else begin : g_grad_ext
        assign grad = {{(COLOR_W - 12){1'b0}}, h_next};
    end

    // Pixel divider: strobe on the last count of each PXL_DIV-clock period
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Next pixel position, wrapping line then frame
    always_comb begin
        h_next = (h_reg == H_LAST) ? 12'd0 : h_reg + 12'd1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            v_next = (v_reg == V_LAST) ? 12'd0 : v_reg + 12'd1;
        end
    end

    // Position counters start on the last pixel so the first strobe lands on (0,0)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_reg <= H_LAST;
            v_reg <= V_LAST;
        end else if (tick) begin
            h_reg <= h_next;
            v_reg <= v_next;
        end
    end

    // Bar index is the number of edges already passed (edges are monotonic)
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + 3'(bar_ge[i]);
        end
    end

    // Pattern decode; bar colour bits are the inverted bar index bits
    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        if (act_next) begin
            case (mode_eff)
                2'd0: begin
                    r_next = bar_idx[1] ? '0 : FULL;
                    g_next = bar_idx[2] ? '0 : FULL;
                    b_next = bar_idx[0] ? '0 : FULL;
                end
                2'd1: begin
                    if ((h_next[3:0] == 4'd0) || (v_next[3:0] == 4'd0)) begin
                        r_next = FULL;
                        g_next = FULL;
                        b_next = FULL;
                    end
                end
                2'd2: begin
                    r_next = grad;
                    g_next = grad;
                    b_next = grad;
                end
                default: begin
                    b_next = FULL;
                end
            endcase
        end
    end

    // Output registers and frame mode latch, all updated on the pixel strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pxlen       <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            active      <= 1'b0;
            hcount      <= 12'd0;
            vcount      <= 12'd0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            mode_reg    <= 2'd0;
        end else begin
            pxlen       <= tick;
            frame_start <= tick && frame_next;
            if (tick) begin
                hsync  <= hs_next;
                vsync  <= vs_next;
                active <= act_next;
                hcount <= h_next;
                vcount <= v_next;
                red    <= r_next;
                green  <= g_next;
                blue   <= b_next;
                if (frame_next) begin
                    mode_reg <= mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Scoreboard bench for vga_timing_pattern. A reference model derives each
// expected pixel from the strobe number since reset (plain modulo arithmetic
// on the frame geometry) and queues it; a monitor pops on every pxlen and
// compares, and checks that outputs hold between strobes. A second instance
// with PXL_DIV=1 and active-high sync is checked for a continuous strobe.
module tb_vga_timing_pattern;

    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 20, VF = 2, VS = 3, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int PD = 3;
    localparam int CW = 5;
    localparam int FV = (1 << CW) - 1;

    typedef struct {
        int stamp;
        int h;
        int v;
        bit act;
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
        bit fs;
    } pix_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode  = 2'd0;
    logic          hsync, vsync, pxlen, active, frame_start;
    logic [CW-1:0] red, green, blue;
    logic [11:0]   hcount, vcount;
    logic          hsync2, vsync2, pxlen2, active2, frame_start2;
    logic [CW-1:0] red2, green2, blue2;
    logic [11:0]   hcount2, vcount2;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_print  = 0;
    pix_t sb[$];

    vga_timing_pattern #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PXL_DIV(PD), .COLOR_W(CW), .SYNC_POL(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .pxlen(pxlen), .active(active), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start)
    );

    vga_timing_pattern #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PXL_DIV(1), .COLOR_W(CW), .SYNC_POL(1'b1)
    ) dut2 (
        .clock(clock), .reset(reset), .mode(mode),
        .hsync(hsync2), .vsync(vsync2), .red(red2), .green(green2), .blue(blue2),
        .pxlen(pxlen2), .active(active2), .hcount(hcount2), .vcount(vcount2),
        .frame_start(frame_start2)
    );

    always #5 clock = ~clock;

    // Expected appearance of pixel number n of the stream, shown in mode md
    function automatic pix_t model_pixel(int n, int md, bit pol);
        pix_t p;
        int   lo, hi;
        p.stamp = 0;
        p.h   = n % HT;
        p.v   = (n / HT) % VT;
        p.act = (p.h < HA) && (p.v < VA);
        p.hs  = (p.h >= HA + HF && p.h < HA + HF + HS) ? pol : !pol;
        p.vs  = (p.v >= VA + VF && p.v < VA + VF + VS) ? pol : !pol;
        p.fs  = (p.h == 0) && (p.v == 0);
        p.r = 0; p.g = 0; p.b = 0;
        if (p.act) begin
            case (md)
                0: begin
                    for (int k = 0; k < 8; k++) begin
                        lo = k * HA / 8;
                        hi = (k + 1) * HA / 8;
                        if (p.h >= lo && p.h < hi) begin
                            case (k)
                                0: begin p.r = FV; p.g = FV; p.b = FV; end // white
                                1: begin p.r = FV; p.g = FV; end           // yellow
                                2: begin p.g = FV; p.b = FV; end           // cyan
                                3: begin p.g = FV; end                     // green
                                4: begin p.r = FV; p.b = FV; end           // magenta
                                5: begin p.r = FV; end                     // red
                                6: begin p.b = FV; end                     // blue
                                default: ;                                 // black
                            endcase
                        end
                    end
                end
                1: if (p.h % 16 == 0 || p.v % 16 == 0) begin
                    p.r = FV; p.g = FV; p.b = FV;
                end
                2: begin p.r = p.h % (FV + 1); p.g = p.r; p.b = p.r; end
                default: p.b = FV;
            endcase
        end
        return p;
    endfunction

    function automatic pix_t reset_pixel();
        pix_t p;
        p.stamp = 0; p.h = 0; p.v = 0; p.act = 0; p.hs = 1; p.vs = 1;
        p.r = 0; p.g = 0; p.b = 0; p.fs = 0;
        return p;
    endfunction

    function automatic pix_t sample_dut();
        pix_t p;
        p.stamp = 0;
        p.h = int'(hcount); p.v = int'(vcount);
        p.act = active; p.hs = hsync; p.vs = vsync;
        p.r = int'(red); p.g = int'(green); p.b = int'(blue);
        p.fs = frame_start;
        return p;
    endfunction

    function automatic bit same_pixel(pix_t a, pix_t e);
        return a.h == e.h && a.v == e.v && a.act == e.act && a.hs == e.hs &&
               a.vs == e.vs && a.r == e.r && a.g == e.g && a.b == e.b && a.fs == e.fs;
    endfunction

    task automatic report(string tag, pix_t a, pix_t e, int cyc);
        n_fail++;
        if (n_print < 30) begin
            n_print++;
            $display("FAIL %s: got h=%0d v=%0d act=%0b hs=%0b vs=%0b rgb=(%0d,%0d,%0d) fs=%0b at cyc %0d, expected h=%0d v=%0d act=%0b hs=%0b vs=%0b rgb=(%0d,%0d,%0d) fs=%0b at cyc %0d",
                     tag, a.h, a.v, a.act, a.hs, a.vs, a.r, a.g, a.b, a.fs, cyc,
                     e.h, e.v, e.act, e.hs, e.vs, e.r, e.g, e.b, e.fs, e.stamp);
        end
    endtask

    // Reference model: one expected pixel per PD clocks since reset release
    int cyc = 0;
    int frame_mode = 0;
    always @(posedge clock or posedge reset) begin
        pix_t p;
        int   n;
        if (reset) begin
            cyc = 0;
            frame_mode = 0;
            sb.delete();
        end else begin
            cyc++;
            if (cyc % PD == 0) begin
                n = cyc / PD - 1;
                if (n % (HT * VT) == 0) frame_mode = int'(mode);
                p = model_pixel(n, frame_mode, 1'b0);
                p.stamp = cyc;
                sb.push_back(p);
            end
        end
    end

    // Monitor: compare on each strobe, check holds in between, check dut2
    int   mcyc = 0;
    pix_t last_exp;
    always @(negedge clock) begin
        pix_t a, e, e2;
        if (reset) begin
            mcyc = 0;
            last_exp = reset_pixel();
        end else begin
            mcyc++;
            a = sample_dut();
            n_checks++;
            if (pxlen) begin
                if (sb.size() == 0) begin
                    e = last_exp;
                    e.stamp = -1;
                    report("unexpected_pxlen", a, e, mcyc);
                end else begin
                    e = sb.pop_front();
                    if (e.stamp != mcyc || !same_pixel(a, e)) report("pixel", a, e, mcyc);
                    last_exp = e;
                end
            end else begin
                e = last_exp;
                e.fs = 0;
                e.stamp = mcyc;
                if (!same_pixel(a, e)) report("hold", a, e, mcyc);
            end
            // Undivided instance presents pixel mcyc-1 on every clock
            e2 = model_pixel(mcyc - 1, 0, 1'b1);
            n_checks++;
            if (pxlen2 !== 1'b1 || int'(hcount2) != e2.h || int'(vcount2) != e2.v ||
                hsync2 !== e2.hs || vsync2 !== e2.vs || frame_start2 !== e2.fs) begin
                n_fail++;
                if (n_print < 30) begin
                    n_print++;
                    $display("FAIL div1_stream: got pxlen=%0b h=%0d v=%0d hs=%0b vs=%0b fs=%0b, expected pxlen=1 h=%0d v=%0d hs=%0b vs=%0b fs=%0b",
                             pxlen2, hcount2, vcount2, hsync2, vsync2, frame_start2,
                             e2.h, e2.v, e2.hs, e2.vs, e2.fs);
                end
            end
        end
    end

    // Stimulus: random-timed mode changes, then an asynchronous mid-frame reset
    initial begin
        bit   found;
        pix_t a, e;
        reset = 1'b1;
        mode  = 2'd0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(400, 3000)) @(negedge clock);
            mode = mode + 2'd1;
        end

        found = 1'b0;
        for (int k = 0; k < 20000 && !found; k++) begin
            @(negedge clock);
            if (hcount == 12'd20 && vcount == 12'd10) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_wait: position (20,10) not reached, got h=%0d v=%0d", hcount, vcount);
        end

        #2 reset = 1'b1;
        #1;
        a = sample_dut();
        e = reset_pixel();
        n_checks++;
        if (!same_pixel(a, e) || pxlen !== 1'b0) report("async_reset", a, e, 0);
        n_checks++;
        if (pxlen2 !== 1'b0 || hcount2 !== 12'd0 || vcount2 !== 12'd0 ||
            hsync2 !== 1'b0 || vsync2 !== 1'b0 || frame_start2 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_div1: got pxlen=%0b h=%0d v=%0d hs=%0b vs=%0b fs=%0b, expected all 0",
                     pxlen2, hcount2, vcount2, hsync2, vsync2, frame_start2);
        end
        mode = 2'($urandom_range(0, 3));
        @(negedge clock);
        #1 reset = 1'b0;

        repeat (6000) @(negedge clock);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pixels never presented, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
